paddsb_seq_unit: RTL and testbench

- Multi-cycle packed saturating add/subtract unit for the ALU's PADDSB-style operation.
- Splits a 4*LANES-bit operand pair into signed 4-bit lanes and processes one lane per clock through a single 4-bit saturating add/sub lane.
- Assembles the packed result and per-lane saturation flags.
- Consumes operands from the execute stage and returns the result under a start/busy/done handshake.

---
 rtl/paddsb_seq_unit.sv | 117 +++++++++++
 tb/tb_paddsb_seq_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/paddsb_seq_unit.sv
// Sequential packed saturating add/sub: one signed 4-bit lane per clock.
// Ports: clk, rst_n, start, sub, a, b -> busy, done, result, sat_flags.
module paddsb_seq_unit #(
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [4*LANES-1:0] a,
  input  logic [4*LANES-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [4*LANES-1:0] result,
  output logic [LANES-1:0] sat_flags
);

  localparam int W  = 4 * LANES;
  localparam int CW = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_q, b_q;
  logic            sub_q;
  logic [W-1:0]    wres, wres_n;
  logic [LANES-1:0] wflg, wflg_n;

  logic [3:0] ai, bi, bx, raw, lres;
  logic       pos, neg, lflg, last;

  assign last = (cnt == CW'(LANES - 1));

  always_comb begin
    ai   = a_q[{cnt, 2'b00} +: 4];
    bi   = b_q[{cnt, 2'b00} +: 4];
    bx   = sub_q ? ~bi : bi;
    raw  = ai + bx + {3'b000, sub_q};
    pos  = ~ai[3] & ~bx[3] & raw[3];
    neg  = ai[3] & bx[3] & ~raw[3];
    lflg = pos | neg;
    lres = raw;
    if (pos) lres = 4'h7;
    if (neg) lres = 4'h8;
  end

  // Working copy with the current lane merged in; the last lane's merge
  // is what gets published, so outputs never see a partial result.
  always_comb begin
    wres_n = wres;
    wflg_n = wflg;
    wres_n[{cnt, 2'b00} +: 4] = lres;
    wflg_n[cnt] = lflg;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = RUN;
      RUN:  if (last) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      wres      <= '0;
      wflg      <= '0;
      result    <= '0;
      sat_flags <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            cnt   <= '0;
            wres  <= '0;
            wflg  <= '0;
          end
        end
        RUN: begin
          wres <= wres_n;
          wflg <= wflg_n;
          if (last) begin
            cnt       <= '0;
            result    <= wres_n;
            sat_flags <= wflg_n;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_paddsb_seq_unit.sv
// Randomized bench for paddsb_seq_unit (LANES=4 and LANES=2 instances).
// Compares against a plain-arithmetic saturating lane model.
module tb_paddsb_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, start2 = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0, b = '0;

  logic        busy4, done4, busy2, done2;
  logic [15:0] res4;
  logic [3:0]  flg4;
  logic [7:0]  res2;
  logic [1:0]  flg2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  paddsb_seq_unit #(.LANES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub),
    .a(a), .b(b), .busy(busy4), .done(done4),
    .result(res4), .sat_flags(flg4)
  );

  paddsb_seq_unit #(.LANES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub),
    .a(a[7:0]), .b(b[7:0]), .busy(busy2), .done(done2),
    .result(res2), .sat_flags(flg2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {flags, result}: true signed sum/difference clamped to [-8, 7].
  function automatic logic [19:0] model(input int lanes, input bit s,
                                        input logic [15:0] x,
                                        input logic [15:0] y);
    logic [15:0] r = '0;
    logic [3:0]  f = '0;
    for (int i = 0; i < lanes; i++) begin
      int va, vb, v;
      va = int'(x[4*i +: 4]);
      vb = int'(y[4*i +: 4]);
      if (va > 7) va -= 16;
      if (vb > 7) vb -= 16;
      v = s ? va - vb : va + vb;
      if (v > 7) begin v = 7; f[i] = 1'b1; end
      if (v < -8) begin v = -8; f[i] = 1'b1; end
      r[4*i +: 4] = 4'(v);
    end
    return {f, r};
  endfunction

  function automatic logic [19:0] outs(input int w);
    return (w == 2) ? {2'b00, flg2, 8'h00, res2} : {flg4, res4};
  endfunction

  // One operation on DUT w (4 or 2). tog: scramble inputs while in flight.
  task automatic run_op(input int w, input bit s, input logic [15:0] x,
                        input logic [15:0] y, input bit tog);
    logic [19:0] exp, prev;
    logic [15:0] xm, ym;
    int n, dones;
    xm = (w == 2) ? {8'h00, x[7:0]} : x;
    ym = (w == 2) ? {8'h00, y[7:0]} : y;
    exp = model(w, s, xm, ym);
    @(negedge clk);
    prev = outs(w);
    sub = s; a = x; b = y;
    if (w == 2) start2 = 1'b1; else start4 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0; start4 = 1'b0;
    n = 0; dones = 0;
    while (dones == 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (((w == 2) ? done2 : done4) == 1'b1) begin
        dones++;
      end else begin
        check("busy_run", 32'((w == 2) ? busy2 : busy4), 32'd1);
        check("hold_out", 32'(outs(w)), 32'(prev));
      end
      if (tog) begin
        sub = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
        if (w == 2) start2 = 1'($urandom); else start4 = 1'($urandom);
      end
    end
    check("latency", 32'(n), 32'(w + 1));
    check("result", 32'(outs(w)), 32'(exp));
    if (tog) begin
      if (w == 2) start2 = 1'b1; else start4 = 1'b1;
      @(negedge clk);
      start2 = 1'b0; start4 = 1'b0;
      check("idle_after", 32'((w == 2) ? {busy2, done2} : {busy4, done4}),
            32'd0);
      check("held_res", 32'(outs(w)), 32'(exp));
    end
  endtask

  initial begin
    #1;
    check("rst_out4", {10'd0, busy4, done4, flg4, res4}, 32'd0);
    check("rst_out2", {20'd0, busy2, done2, flg2, res2}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(4, 1'b0, 16'h1234, 16'h1111, 1'b0);
    check("t1", 32'({flg4, res4}), 32'h0_2345);
    run_op(4, 1'b0, 16'h5A3F, 16'h3C21, 1'b0);
    check("t2", 32'({flg4, res4}), 32'hC_7850);
    run_op(4, 1'b1, 16'h0000, 16'h8888, 1'b0);
    check("t3", 32'({flg4, res4}), 32'hF_7777);
    run_op(4, 1'b1, 16'h8000, 16'h1000, 1'b0);
    check("t4", 32'({flg4, res4}), 32'h8_8000);
    run_op(4, 1'b0, 16'h7F18, 16'h0912, 1'b1);
    run_op(2, 1'b0, 16'h0077, 16'h0011, 1'b0);
    check("t_l2", 32'({flg2, res2}), 32'h3_77);

    run_op(4, 1'b0, 16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    sub = 1'b0; a = 16'h7777; b = 16'h1111; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out", {11'd0, busy4, flg4, res4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int pulses = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (done4) pulses++;
      end
      check("abort_nodone", 32'(pulses), 32'd0);
    end
    check("abort_hold", 32'({busy4, flg4, res4}), 32'd0);
    run_op(4, 1'b0, 16'h1234, 16'h1111, 1'b0);
    check("after_abort", 32'({flg4, res4}), 32'h0_2345);

    for (int i = 0; i < 30; i++)
      run_op(4, 1'($urandom), 16'($urandom), 16'($urandom),
             1'($urandom));
    for (int i = 0; i < 15; i++)
      run_op(2, 1'($urandom), 16'($urandom), 16'($urandom),
             1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
